// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, big-endian instruction ROM read, next-PC
// selection (sequential / branch-on-zero / jump / jr) and run-state tracking.
module fetch_unit #(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_z,
    input  logic        zero,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    localparam int unsigned AW       = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [31:0] MEM_SIZE = 32'(IMEM_BYTES);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    // Instruction store; contents preloaded externally, no write port.
    logic [7:0] bytes [0:IMEM_BYTES-1];

    logic [1:0]  state, state_d;
    logic [31:0] pc_d, retired_d;
    logic [31:0] fetched;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        bad_target;

    // Out-of-range byte addresses read as zero (only reachable with a bad RESET_PC).
    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        logic [7:0] b;
        b = 8'h00;
        if (a < MEM_SIZE) begin
            b = bytes[a[AW-1:0]];
        end
        return b;
    endfunction

    always_comb begin
        fetched = {rd_byte(pc), rd_byte(pc + 32'd1), rd_byte(pc + 32'd2), rd_byte(pc + 32'd3)};
    end

    assign pc_plus4   = pc + 32'd4;
    assign instr      = (state == ST_RUN) ? fetched : 32'h0000_0000;
    assign halted     = (state == ST_HALTED);
    assign fault      = (state == ST_FAULT);
    assign branch_off = {{14{fetched[15]}}, fetched[15:0], 2'b00};

    // Target selection: jr > jump > taken branch > sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], fetched[25:0], 2'b00};
        end else if (branch_z && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
        bad_target = (next_pc[1:0] != 2'b00) || ((next_pc + 32'd3) >= MEM_SIZE);
    end

    // Next state, PC and retire count; halt outranks the fault check.
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        retired_d = retired;
        if (state == ST_RUN && !stall) begin
            if (halt) begin
                state_d = ST_HALTED;
                if (retired != 32'hFFFF_FFFF) retired_d = retired + 32'd1;
            end else if (bad_target) begin
                state_d = ST_FAULT;
            end else begin
                pc_d = next_pc;
                if (retired != 32'hFFFF_FFFF) retired_d = retired + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            pc      <= RESET_PC;
            retired <= 32'h0000_0000;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            retired <= retired_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, branches, jumps, fault and stall/halt behaviour.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, halt, branch_z, zero, jump, jr;
    logic [31:0] jr_target;
    logic [31:0] instr, pc, pc_plus4, retired;
    logic        halted, fault;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.IMEM_BYTES(1024), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
        .branch_z(branch_z), .zero(zero), .jump(jump), .jr(jr),
        .jr_target(jr_target), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic put_word(input int unsigned a, input logic [31:0] w);
        dut.bytes[a]     = w[31:24];
        dut.bytes[a + 1] = w[23:16];
        dut.bytes[a + 2] = w[15:8];
        dut.bytes[a + 3] = w[7:0];
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; branch_z = 0; zero = 0; jump = 0; jr = 0; jr_target = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 0;
        #1;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 1;
        idle_inputs();
        step();
        rst_n = 0;
        #1;
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (instr !== 32'h2004_0000) begin n_err++; $display("FAIL reset_instr: got %h want %h", instr, 32'h2004_0000); end
        n_cmp++; if (retired !== 32'h0) begin n_err++; $display("FAIL reset_retired: got %h want 0", retired); end
        n_cmp++; if (halted !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL reset_flags: got h=%b f=%b want 0 0", halted, fault); end
        n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_pc_plus4: got %h want 4", pc_plus4); end
        @(negedge clk);
        rst_n = 1;
        step();
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL first_edge_pc: got %h want 4", pc); end
        n_cmp++; if (retired !== 32'h1) begin n_err++; $display("FAIL first_edge_retired: got %h want 1", retired); end
    endtask

    task automatic test_branch();
        step();
        branch_z = 1; zero = 1;
        step();
        n_cmp++; if (pc !== 32'h18) begin n_err++; $display("FAIL branch_taken: got %h want 18", pc); end
        n_cmp++; if (retired !== 32'h3) begin n_err++; $display("FAIL branch_taken_retired: got %h want 3", retired); end
        do_reset();
        step(); step();
        branch_z = 1; zero = 0;
        step();
        n_cmp++; if (pc !== 32'hC) begin n_err++; $display("FAIL branch_not_taken: got %h want c", pc); end
        idle_inputs();
        step();
        branch_z = 1; zero = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL branch_self_loop: got %h want 10", pc); end
            n_cmp++; if (retired !== 32'(5 + i)) begin n_err++; $display("FAIL self_loop_retired: got %0d want %0d", retired, 5 + i); end
        end
    endtask

    task automatic test_jump();
        idle_inputs();
        jr = 1; jr_target = 32'h20;
        step();
        n_cmp++; if (pc !== 32'h20) begin n_err++; $display("FAIL jr_target: got %h want 20", pc); end
        idle_inputs();
        jump = 1;
        step();
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL jump_target: got %h want 100", pc); end
        n_cmp++; if (pc_plus4 !== 32'h104) begin n_err++; $display("FAIL jump_pc_plus4: got %h want 104", pc_plus4); end
        jr = 1; jr_target = 32'h40;
        step();
        n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL jr_over_jump: got %h want 40", pc); end
        n_cmp++; if (retired !== 32'h9) begin n_err++; $display("FAIL jump_retired: got %0d want 9", retired); end
    endtask

    task automatic test_fault();
        idle_inputs();
        jr = 1; jr_target = 32'h102;
        step();
        n_cmp++; if (fault !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL misalign_fault: got f=%b h=%b want 1 0", fault, halted); end
        n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL fault_pc_held: got %h want 40", pc); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL fault_instr: got %h want 0", instr); end
        n_cmp++; if (retired !== 32'h9) begin n_err++; $display("FAIL fault_retired: got %0d want 9", retired); end
        jr = 0; jump = 1;
        step(); step();
        n_cmp++; if (pc !== 32'h40 || fault !== 1'b1) begin n_err++; $display("FAIL fault_sticky: got pc=%h f=%b want 40 1", pc, fault); end
        rst_n = 0;
        #1;
        n_cmp++; if (pc !== 32'h0 || fault !== 1'b0 || retired !== 32'h0) begin n_err++; $display("FAIL fault_reset: got pc=%h f=%b r=%0d want 0 0 0", pc, fault, retired); end
        do_reset();
        jr = 1; jr_target = 32'h3FC;
        step();
        n_cmp++; if (pc !== 32'h3FC || fault !== 1'b0) begin n_err++; $display("FAIL last_word_ok: got pc=%h f=%b want 3fc 0", pc, fault); end
        jr_target = 32'h400;
        step();
        n_cmp++; if (fault !== 1'b1 || pc !== 32'h3FC) begin n_err++; $display("FAIL range_fault: got pc=%h f=%b want 3fc 1", pc, fault); end
        n_cmp++; if (retired !== 32'h1) begin n_err++; $display("FAIL range_fault_retired: got %0d want 1", retired); end
    endtask

    task automatic test_stall_halt();
        do_reset();
        step();
        stall = 1; jr = 1; jr_target = 32'h20;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (pc !== 32'h4 || retired !== 32'h1) begin n_err++; $display("FAIL stall_hold: got pc=%h r=%0d want 4 1", pc, retired); end
        end
        jr = 0; halt = 1;
        step();
        n_cmp++; if (halted !== 1'b0 || pc !== 32'h4) begin n_err++; $display("FAIL stall_over_halt: got h=%b pc=%h want 0 4", halted, pc); end
        stall = 0;
        step();
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_taken: got %b want 1", halted); end
        n_cmp++; if (retired !== 32'h2 || pc !== 32'h4) begin n_err++; $display("FAIL halt_retire: got r=%0d pc=%h want 2 4", retired, pc); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL halt_instr: got %h want 0", instr); end
        halt = 0; jr = 1; jr_target = 32'h8;
        step(); step();
        n_cmp++; if (pc !== 32'h4 || retired !== 32'h2 || halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got pc=%h r=%0d h=%b want 4 2 1", pc, retired, halted); end
    endtask

    initial begin
        rst_n = 1;
        idle_inputs();
        for (int i = 0; i < 1024; i++) dut.bytes[i] = 8'h00;
        put_word(32'h00, 32'h2004_0000);
        put_word(32'h08, 32'h1000_0003);
        put_word(32'h10, 32'h1000_FFFF);
        put_word(32'h20, 32'h0800_0040);
        test_reset();
        test_branch();
        test_jump();
        test_fault();
        test_stall_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
